itch_length_framer: RTL and testbench
=====================================

Name: itch_length_framer

Overview:
Upstream stage feeding the integrated ITCH decoder bank. Accepts a raw SoupBinTCP-style byte stream in which every message carries a 2-byte big-endian length prefix. Strips the prefix and forwards payload bytes on the byte_in/valid_in interface the decoders consume. Forces a valid-low gap between messages so every speculative decoder restarts its byte counter cleanly, and discards oversize or zero-length frames.

Parameters:
MAX_MSG_LEN, 64, largest accepted payload length in bytes; longer frames are consumed but not forwarded
GAP_CYCLES, 1, number of idle cycles (valid_out low, s_ready low) inserted after each forwarded message; legal range 1..15
CNT_W, 32, width of the statistics counters (optional feature)

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
s_data  in  8  upstream stream byte
s_valid  in  1  s_data valid
s_ready  out  1  framer can accept; a byte transfers when s_valid && s_ready
byte_out  out  8  payload byte to decoders (drives byte_in)
valid_out  out  1  payload byte valid (drives valid_in)
msg_start  out  1  pulse with the first payload byte
msg_end  out  1  pulse with the last payload byte
msg_len  out  16  length of the current/last forwarded message, held until the next header completes
frame_err  out  1  one-cycle pulse when a header is decoded with length 0 or > MAX_MSG_LEN
msg_count  out  CNT_W  forwarded-message counter (FRAMER_STATS_EN only)
drop_count  out  CNT_W  dropped-frame counter (FRAMER_STATS_EN only)

Behaviour:
- Reset (async assert, sync release): state=LEN_HI; byte_out=0, valid_out=0, msg_start=0, msg_end=0, msg_len=0, frame_err=0, counters=0; s_ready=0 while rst high, 1 in LEN_HI afterwards.
- Outputs are registered; each accepted payload byte appears on byte_out/valid_out exactly 1 cycle after its transfer.
- States:
  LEN_HI: s_ready=1; on transfer latch len[15:8] -> LEN_LO.
  LEN_LO: s_ready=1; on transfer form len = {hi, s_data}, remaining=len.
    len==0 -> frame_err pulse, -> LEN_HI (nothing forwarded).
    len>MAX_MSG_LEN -> frame_err pulse, -> DROP.
    otherwise msg_len<=len, -> PAYLOAD.
  PAYLOAD: s_ready=1; each transfer forwards the byte, decrements remaining. The first byte raises msg_start. The byte taking remaining from 1 to 0 raises msg_end -> GAP.
  DROP: s_ready=1; consume bytes with valid_out=0. When remaining reaches 0 -> LEN_HI, no gap.
  GAP: s_ready=0, valid_out=0 for GAP_CYCLES cycles (down-counter), then -> LEN_HI.
- s_valid low in any state: hold state; valid_out=0 that cycle (bubbles pass through to decoders unchanged).
- len==1: msg_start and msg_end are asserted on the same byte.
- Header bytes never appear on valid_out.
- msg_len is not updated for dropped or zero-length frames.
- The remaining counter is 16 bits; no wrap, because decrement only occurs while remaining>0.
- Reset asserted mid-message aborts immediately: the partial message is discarded and the next accepted byte is treated as LEN_HI.
- s_ready is a function of registered state only (no combinational path from s_valid).

Optional Feature:
FRAMER_STATS_EN
- Defined: msg_count increments on each msg_end. drop_count increments on each frame_err. Both saturate at all-ones and reset to 0.
- Undefined: msg_count and drop_count are tied to 0 and no counter registers are built.

Test Plan:
- Stream 00 24 'A' + 35 bytes, s_valid continuous -> 36 valid_out bytes starting 1 cycle after the 'A' transfer. msg_start on 'A', msg_end on byte 36, msg_len=36. Then s_ready low for 1 cycle; add_internal_valid fires downstream.
- Back-to-back messages 00 17 'X'... and 00 0B 'D'... with GAP_CYCLES=3 -> exactly 3 cycles with valid_out=0 and s_ready=0 between the 23rd byte of the first and the first byte of the second.
- Header 00 00 followed by 00 05 + 5 bytes -> frame_err pulse after the 2nd byte, nothing forwarded for it. The second message forwards 5 bytes with msg_len=5.
- Header 01 00 (256 > 64) + 256 bytes, then 00 03 AA BB CC -> frame_err pulse, zero valid_out during the drop, then AA BB CC forwarded. With FRAMER_STATS_EN: drop_count=1, msg_count=1.
- Random s_valid deassertion (50%) during a 36-byte message -> payload order preserved, and valid_out high only on cycles after accepted bytes.
- rst asserted for 1 cycle after 10 of 36 payload bytes -> all outputs 0 asynchronously. The following 00 0B + 11 bytes is framed correctly with msg_len=11.

Source files
------------

// File: rtl/itch_length_framer.sv
// Length-prefix framer: strips 2-byte big-endian length headers, forwards payload with a forced idle gap,
// drops zero/oversize frames. Optional statistics counters built only when FRAMER_STATS_EN is defined.
module itch_length_framer #(
    parameter int MAX_MSG_LEN = 64,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       byte_out,
    output logic             valid_out,
    output logic             msg_start,
    output logic             msg_end,
    output logic [15:0]      msg_len,
    output logic             frame_err,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [2:0] {LEN_HI, LEN_LO, PAYLOAD, DROP, GAP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] remaining;
    logic [3:0]  gap_cnt;
    logic        first;
    logic        xfer;
    logic [15:0] len_full;
    logic        len_bad;

    assign len_full = {len_hi, s_data};
    assign len_bad  = (len_full == 16'd0) || (len_full > 16'(MAX_MSG_LEN));
    assign xfer     = s_valid && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LEN_HI;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LEN_HI:  if (xfer) state_nxt = LEN_LO;
            LEN_LO:  if (xfer) begin
                         if (len_full == 16'd0)                    state_nxt = LEN_HI;
                         else if (len_full > 16'(MAX_MSG_LEN))     state_nxt = DROP;
                         else                                      state_nxt = PAYLOAD;
                     end
            PAYLOAD: if (xfer && remaining == 16'd1) state_nxt = GAP;
            DROP:    if (xfer && remaining == 16'd1) state_nxt = LEN_HI;
            GAP:     if (gap_cnt == 4'd0) state_nxt = LEN_HI;
            default: state_nxt = LEN_HI;
        endcase
    end

    // Ready depends only on registered state, never on s_valid.
    always_comb begin
        s_ready = !rst && (state != GAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi    <= 8'd0;
            remaining <= 16'd0;
            gap_cnt   <= 4'd0;
            first     <= 1'b0;
            byte_out  <= 8'd0;
            valid_out <= 1'b0;
            msg_start <= 1'b0;
            msg_end   <= 1'b0;
            msg_len   <= 16'd0;
            frame_err <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            msg_start <= 1'b0;
            msg_end   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                LEN_HI: if (xfer) len_hi <= s_data;
                LEN_LO: if (xfer) begin
                    remaining <= len_full;
                    first     <= 1'b1;
                    frame_err <= len_bad;
                    if (!len_bad) msg_len <= len_full;
                end
                PAYLOAD: if (xfer && remaining != 16'd0) begin
                    byte_out  <= s_data;
                    valid_out <= 1'b1;
                    msg_start <= first;
                    first     <= 1'b0;
                    msg_end   <= (remaining == 16'd1);
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) gap_cnt <= 4'(GAP_CYCLES - 1);
                end
                DROP: if (xfer && remaining != 16'd0) remaining <= remaining - 16'd1;
                GAP:  if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                default: ;
            endcase
        end
    end

`ifdef FRAMER_STATS_EN
    logic [CNT_W-1:0] msg_cnt_q, drop_cnt_q;

    // Both counters saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (msg_end && !(&msg_cnt_q))    msg_cnt_q  <= msg_cnt_q + CNT_W'(1);
            if (frame_err && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign msg_count  = msg_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    assign msg_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_itch_length_framer.sv
// Directed bench for itch_length_framer (GAP_CYCLES=3): framing, gap, drop/zero-length frames,
// random bubbles and mid-message reset, with a negedge monitor collecting forwarded bytes.
module tb_itch_length_framer;

    localparam int GAPC = 3;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    byte_out;
    logic          valid_out;
    logic          msg_start;
    logic          msg_end;
    logic [15:0]   msg_len;
    logic          frame_err;
    logic [CW-1:0] msg_count;
    logic [CW-1:0] drop_count;

    itch_length_framer #(.MAX_MSG_LEN(64), .GAP_CYCLES(GAPC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .byte_out(byte_out), .valid_out(valid_out), .msg_start(msg_start), .msg_end(msg_end),
        .msg_len(msg_len), .frame_err(frame_err), .msg_count(msg_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         nerr  = 0;
    int         nrdy  = 0;
    logic       xfer_prev = 1'b0;
    logic [7:0] rx_b[$];
    bit         rx_s[$];
    bit         rx_e[$];
    int         rx_c[$];
    logic [7:0] exp_q[$];

    // Monitor: collect forwarded bytes; each must follow an accepted transfer one cycle earlier.
    always @(negedge clk) begin
        cyc++;
        if (valid_out) begin
            rx_b.push_back(byte_out);
            rx_s.push_back(msg_start);
            rx_e.push_back(msg_end);
            rx_c.push_back(cyc);
            total++;
            assert (xfer_prev === 1'b1) else begin
                bad++;
                $error("FAIL vld_after_xfer: observed %0b expected 1 (cycle %0d)", xfer_prev, cyc);
            end
        end
        if (frame_err) nerr++;
        if (!rst && !s_ready) nrdy++;
        xfer_prev = s_valid && s_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int g;
        s_data  = b;
        s_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!s_ready && g < 100) begin
            g++;
            @(negedge clk);
        end
        if (g >= 100) chk("push_timeout", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hdr(input int len);
        logic [15:0] l;
        l = 16'(len);
        push(l[15:8]);
        push(l[7:0]);
    endtask

    task automatic clear();
        rx_b.delete(); rx_s.delete(); rx_e.delete(); rx_c.delete(); exp_q.delete();
    endtask

    task automatic check_rx(input string tag, input int ns, input int ne);
        int s, e;
        s = 0; e = 0;
        chk({tag, "_count"}, rx_b.size(), exp_q.size());
        for (int i = 0; i < rx_b.size(); i++) begin
            if (i < exp_q.size()) chk({tag, "_byte"}, {24'd0, rx_b[i]}, {24'd0, exp_q[i]});
            s += int'(rx_s[i]);
            e += int'(rx_e[i]);
        end
        chk({tag, "_starts"}, s, ns);
        chk({tag, "_ends"}, e, ne);
        if (rx_b.size() > 0) begin
            chk({tag, "_first_start"}, {31'd0, rx_s[0]}, 32'd1);
            chk({tag, "_last_end"}, {31'd0, rx_e[rx_e.size()-1]}, 32'd1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        chk({tag, "_byte"}, {24'd0, byte_out}, 32'd0);
        chk({tag, "_start"}, {31'd0, msg_start}, 32'd0);
        chk({tag, "_end"}, {31'd0, msg_end}, 32'd0);
        chk({tag, "_len"}, {16'd0, msg_len}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
    endtask

    initial begin
        int n, r0, e0;
        logic [7:0] b;
        rst = 1'b1; s_valid = 1'b0; s_data = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        chk("rst_msg_count", msg_count, 32'd0);
        chk("rst_drop_count", drop_count, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 36-byte message, continuous valid
        clear();
        hdr(36);
        for (int i = 0; i < 36; i++) begin
            b = 8'(65 + i);
            exp_q.push_back(b);
            push(b);
        end
        chk("s1_end_now", {31'd0, msg_end}, 32'd1);
        n = 0;
        while (!s_ready && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("s1_gap_cycles", n, GAPC);
        chk("s1_msg_len", {16'd0, msg_len}, 32'd36);
        idle(1);
        check_rx("s1", 1, 1);
        if (rx_c.size() == 36) chk("s1_contig", rx_c[35] - rx_c[0], 35);

        // Back-to-back messages with forced gap
        clear();
        r0 = nrdy;
        hdr(23);
        for (int i = 0; i < 23; i++) begin
            b = 8'(88 + i);
            exp_q.push_back(b);
            push(b);
        end
        hdr(11);
        chk("s2_gap_ready_low", nrdy - r0, GAPC);
        for (int i = 0; i < 11; i++) begin
            b = 8'(68 + i);
            exp_q.push_back(b);
            push(b);
        end
        idle(6);
        check_rx("s2", 2, 2);
        if (rx_b.size() == 34) begin
            chk("s2_end_a", {31'd0, rx_e[22]}, 32'd1);
            chk("s2_start_b", {31'd0, rx_s[23]}, 32'd1);
            chk("s2_spacing", rx_c[23] - rx_c[22], 6);
        end

        // Zero-length header, then 5-byte, 1-byte and MAX-length messages
        clear();
        e0 = nerr;
        push(8'h00);
        push(8'h00);
        chk("s3_ferr_pulse", {31'd0, frame_err}, 32'd1);
        hdr(5);
        for (int i = 0; i < 5; i++) begin
            b = 8'(16 + i);
            exp_q.push_back(b);
            push(b);
        end
        chk("s3_len5", {16'd0, msg_len}, 32'd5);
        hdr(1);
        exp_q.push_back(8'h55);
        push(8'h55);
        hdr(64);
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            exp_q.push_back(b);
            push(b);
        end
        idle(6);
        chk("s3_ferr_count", nerr - e0, 1);
        check_rx("s3", 3, 3);
        if (rx_b.size() == 70) begin
            chk("s3_one_start", {31'd0, rx_s[5]}, 32'd1);
            chk("s3_one_end", {31'd0, rx_e[5]}, 32'd1);
        end
        chk("s3_len64", {16'd0, msg_len}, 32'd64);

        // Oversize frame dropped, followed by a good 3-byte message
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear();
        e0 = nerr;
        push(8'h01);
        push(8'h00);
        chk("s4_ferr_pulse", {31'd0, frame_err}, 32'd1);
        for (int i = 0; i < 256; i++) push(8'(i));
        hdr(3);
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
        push(8'hAA); push(8'hBB); push(8'hCC);
        idle(6);
        chk("s4_ferr_count", nerr - e0, 1);
        check_rx("s4", 1, 1);
        chk("s4_msg_len", {16'd0, msg_len}, 32'd3);
`ifdef FRAMER_STATS_EN
        chk("s4_msg_count", msg_count, 32'd1);
        chk("s4_drop_count", drop_count, 32'd1);
`else
        chk("s4_msg_count", msg_count, 32'd0);
        chk("s4_drop_count", drop_count, 32'd0);
`endif

        // Random bubbles on s_valid
        clear();
        hdr(36);
        for (int i = 0; i < 36; i++) begin
            b = 8'(200 - i);
            exp_q.push_back(b);
            if ($urandom_range(0, 1) == 1) idle(1);
            push(b);
        end
        idle(6);
        check_rx("s5", 1, 1);
        chk("s5_msg_len", {16'd0, msg_len}, 32'd36);

        // Reset in the middle of a message
        hdr(36);
        for (int i = 0; i < 10; i++) push(8'(i + 1));
        rst = 1'b1;
        #1;
        chk_all_zero("s6_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear();
        hdr(11);
        for (int i = 0; i < 11; i++) begin
            b = 8'(150 + i);
            exp_q.push_back(b);
            push(b);
        end
        idle(6);
        check_rx("s6", 1, 1);
        chk("s6_msg_len", {16'd0, msg_len}, 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
